// File: rtl/conv_weight_streamer_pkg.sv
// Shared definitions for the conv weight streamer: default conv geometry, word count helpers
// and the stream FSM state encoding.
package conv_weight_streamer_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_CHANNEL_NUM_IN  = 512;
    localparam int DEF_CHANNEL_NUM_OUT = 512;
    localparam int DEF_KERNEL          = 3;

    function automatic int total_words(input int channel_num_in, input int channel_num_out,
                                       input int kernel);
        return channel_num_out * channel_num_in * kernel * kernel;
    endfunction

    localparam int DEF_TOTAL_WORDS = total_words(DEF_CHANNEL_NUM_IN, DEF_CHANNEL_NUM_OUT, DEF_KERNEL);
    localparam int DEF_ADDR_WIDTH  = $clog2(DEF_TOTAL_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } stream_state_t;

endpackage

// File: rtl/conv_weight_streamer_if.sv
// Weight memory read port plus the valid/ready weight stream toward the conv top.
interface conv_weight_streamer_if
    import conv_weight_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  weight_ready;
    logic                  valid_weight_out;
    logic [DATA_WIDTH-1:0] weight_out;

    modport master (
        output mem_rd_en, mem_addr, valid_weight_out, weight_out,
        input  mem_rd_data, weight_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, valid_weight_out, weight_out,
        output mem_rd_data, weight_ready
    );

endinterface

// File: rtl/conv_weight_streamer_fifo2.sv
// weight_stream_fifo2: 2-deep first-word-fall-through buffer with a registered head and count.
module weight_stream_fifo2
    import conv_weight_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] tail;

    // The head register always holds the oldest word, so the consumer sees it without a read delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= push_data;
                    else               tail <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (count != 2'd0);

endmodule

// File: rtl/conv_weight_streamer.sv
// Streams a full conv weight set from a synchronous weight memory as a valid/ready word stream.
// Optional macro WEIGHT_STREAM_CHECKSUM_EN adds an XOR checksum of all transferred words.
module conv_weight_streamer
    import conv_weight_streamer_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
    parameter int CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT,
    parameter int KERNEL          = DEF_KERNEL,
    parameter int ADDR_WIDTH      = $clog2(total_words(CHANNEL_NUM_IN, CHANNEL_NUM_OUT, KERNEL))
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    conv_weight_streamer_if.master bus
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int TOTAL_WORDS = total_words(CHANNEL_NUM_IN, CHANNEL_NUM_OUT, KERNEL);
    localparam int CNT_WIDTH   = $clog2(TOTAL_WORDS + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(TOTAL_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0]  LAST_COUNT = CNT_WIDTH'(TOTAL_WORDS - 1);

    stream_state_t         state;
    stream_state_t         state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  accepted;
    logic                  inflight;
    logic                  rd_en;
    logic                  pop;
    logic                  start_accept;
    logic                  last_xfer;
    logic [1:0]            fifo_count;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [2:0]            occupancy;

    assign pop          = fifo_valid & bus.weight_ready;
    assign start_accept = (state == IDLE) & start;
    assign last_xfer    = pop & (accepted == LAST_COUNT);
    // Words already owed to the buffer after this cycle's pop; a read is safe only below 2.
    assign occupancy    = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = STREAM;
            end
            STREAM: begin
                rd_en = (occupancy < 3'd2);
                if (rd_en && (addr == LAST_ADDR)) state_next = DRAIN;
            end
            DRAIN: begin
                if (last_xfer) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr     <= '0;
            accepted <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (start_accept) begin
                addr     <= '0;
                accepted <= '0;
            end else begin
                if (rd_en && (addr != LAST_ADDR)) addr <= addr + 1'b1;
                if (pop) accepted <= accepted + 1'b1;
            end
        end
    end

    weight_stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (bus.mem_rd_data),
        .pop       (pop),
        .valid     (fifo_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign busy                 = (state == STREAM) || (state == DRAIN);
    assign done                 = (state == DONE);
    assign bus.mem_rd_en        = rd_en;
    assign bus.mem_addr         = addr;
    assign bus.valid_weight_out = fifo_valid;
    assign bus.weight_out       = fifo_head;

`ifdef WEIGHT_STREAM_CHECKSUM_EN
    // No pops happen outside a stream, so the value naturally holds from done until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            checksum <= '0;
        else if (start_accept) checksum <= '0;
        else if (pop)          checksum <= checksum ^ fifo_head;
    end
`endif

endmodule

// File: tb/tb_conv_weight_streamer.sv
// Bench for conv_weight_streamer: memory returns addr+100, stream compared against a word-index model.
// Build with WEIGHT_STREAM_CHECKSUM_EN to also exercise the checksum output.
module tb_conv_weight_streamer;

    localparam int DW    = 32;
    localparam int CIN   = 2;
    localparam int COUT  = 2;
    localparam int K     = 3;
    localparam int TOTAL = CIN * COUT * K * K;
    localparam int AW    = $clog2(TOTAL);

    typedef struct {
        int ready_pct;
        int hold_low;
        int exp_stall_reads;
        int exp_words;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int checks = 0;
    int errors = 0;
    int words_rx = 0;
    int reads_issued = 0;
    int done_count = 0;
    logic hold_pending = 1'b0;
    logic last_xfer_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;

    conv_weight_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    conv_weight_streamer #(
        .DATA_WIDTH      (DW),
        .CHANNEL_NUM_IN  (CIN),
        .CHANNEL_NUM_OUT (COUT),
        .KERNEL          (K),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
`ifdef WEIGHT_STREAM_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= {{(DW-AW){1'b0}}, bus.mem_addr} + DW'(100);
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

`ifdef WEIGHT_STREAM_CHECKSUM_EN
    function automatic logic [DW-1:0] ref_xor();
        logic [DW-1:0] acc = '0;
        for (int i = 0; i < TOTAL; i++) acc ^= DW'(100 + i);
        return acc;
    endfunction
`endif

    // Reference: word n of a stream must be n+100, reads go out in address order and never
    // more than two words are owed to the consumer.
    always @(negedge clk) begin
        if (!reset) begin
            words_rx       = 0;
            reads_issued   = 0;
            hold_pending   = 1'b0;
            last_xfer_prev = 1'b0;
        end else begin
            logic pop_now;
            int   owed;
            pop_now = bus.valid_weight_out & bus.weight_ready;
            if (hold_pending) begin
                check_output("hold_valid", bus.valid_weight_out, 1);
                check_output("hold_data", bus.weight_out, hold_data);
            end
            if (start && !busy && !done) begin
                words_rx     = 0;
                reads_issued = 0;
            end
            if (bus.mem_rd_en) begin
                owed = reads_issued - words_rx + 1 - (pop_now ? 1 : 0);
                check_output("rd_addr", bus.mem_addr, reads_issued);
                check_output("rd_range", reads_issued < TOTAL, 1);
                check_output("owed_bound", owed <= 2, 1);
            end
            if (done) begin
                done_count++;
                check_output("done_words", words_rx, TOTAL);
                check_output("done_timing", last_xfer_prev, 1);
`ifdef WEIGHT_STREAM_CHECKSUM_EN
                check_output("checksum_done", checksum, ref_xor());
`endif
            end
            last_xfer_prev = pop_now && (words_rx == TOTAL - 1);
            if (pop_now) begin
                check_output("word_value", bus.weight_out, DW'(100 + words_rx));
                words_rx++;
            end
            if (bus.mem_rd_en) reads_issued++;
            hold_pending = bus.valid_weight_out & ~bus.weight_ready;
            hold_data    = bus.weight_out;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int c = 0; c < 2000 && done_count == d0; c++) begin
            @(posedge clk); #1;
        end
        check_output("done_seen", done_count - d0, 1);
    endtask

    task automatic apply_stimulus(input int pct, input int hold, output int stall_reads, output int n_done);
        int d0;
        d0 = done_count;
        stall_reads = -1;
        bus.weight_ready = (hold > 0) ? 1'b0 : 1'b1;
        pulse_start();
        for (int c = 0; c < 3000 && done_count == d0; c++) begin
            bus.weight_ready = (c < hold) ? 1'b0 : (int'($urandom_range(0, 99)) < pct);
            @(posedge clk); #1;
            if (c == hold - 1) stall_reads = reads_issued;
        end
        n_done = done_count - d0;
    endtask

    initial begin
        vec_t vecs[4];
        int   stall_reads;
        int   n_done;
        int   d0;

        vecs[0] = '{ready_pct: 100, hold_low: 0,  exp_stall_reads: 0, exp_words: TOTAL, exp_done: 1};
        vecs[1] = '{ready_pct: 50,  hold_low: 0,  exp_stall_reads: 0, exp_words: TOTAL, exp_done: 1};
        vecs[2] = '{ready_pct: 100, hold_low: 20, exp_stall_reads: 2, exp_words: TOTAL, exp_done: 1};
        vecs[3] = '{ready_pct: 30,  hold_low: 7,  exp_stall_reads: 2, exp_words: TOTAL, exp_done: 1};

        bus.weight_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_rd_en", bus.mem_rd_en, 0);
        check_output("rst_addr", bus.mem_addr, 0);
        check_output("rst_valid", bus.valid_weight_out, 0);
        check_output("rst_data", bus.weight_out, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Latency: start sampled at E0, read of address 0 right after, first valid after E2.
        $display("[TB] latency and free-run");
        d0 = done_count;
        bus.weight_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("e0_busy", busy, 1);
        check_output("e0_rd_en", bus.mem_rd_en, 1);
        check_output("e0_addr", bus.mem_addr, 0);
        check_output("e0_valid", bus.valid_weight_out, 0);
`ifdef WEIGHT_STREAM_CHECKSUM_EN
        check_output("checksum_clear", checksum, 0);
`endif
        @(posedge clk); #1;
        check_output("e1_valid", bus.valid_weight_out, 0);
        @(posedge clk); #1;
        check_output("e2_valid", bus.valid_weight_out, 1);
        check_output("e2_data", bus.weight_out, 100);
        wait_done(d0);
        @(posedge clk); #1;
        check_output("post_busy", busy, 0);
        check_output("post_done", done, 0);

        $display("[TB] table-driven ready patterns");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i].ready_pct, vecs[i].hold_low, stall_reads, n_done);
            if (vecs[i].hold_low > 0) check_output("stall_reads", stall_reads, vecs[i].exp_stall_reads);
            check_output("vec_done", n_done, vecs[i].exp_done);
            check_output("vec_words", words_rx, vecs[i].exp_words);
            repeat (5) @(posedge clk);
            #1;
            check_output("vec_idle_busy", busy, 0);
`ifdef WEIGHT_STREAM_CHECKSUM_EN
            check_output("checksum_hold", checksum, ref_xor());
`endif
        end

        $display("[TB] start during stream and during done");
        d0 = done_count;
        bus.weight_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 200 && words_rx < 10; c++) begin
            @(posedge clk); #1;
        end
        pulse_start();
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk); #1;
        end
        check_output("in_done_cycle", done, 1);
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        check_output("ign_busy", busy, 0);
        check_output("ign_done_count", done_count - d0, 1);
        check_output("ign_words", words_rx, TOTAL);

        $display("[TB] reset mid-stream");
        d0 = done_count;
        bus.weight_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 200 && words_rx < 20; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        check_output("abort_rd_en", bus.mem_rd_en, 0);
        check_output("abort_addr", bus.mem_addr, 0);
        check_output("abort_valid", bus.valid_weight_out, 0);
        check_output("abort_data", bus.weight_out, 0);
        repeat (5) @(posedge clk);
        #1;
        check_output("abort_no_done", done_count - d0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(100, 0, stall_reads, n_done);
        check_output("restart_done", n_done, 1);
        check_output("restart_words", words_rx, TOTAL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_weight_streamer.md
Name: conv_weight_streamer

Overview:
- Transmit end of the conv weight interface (valid_weight_in / weight_in) of the 3x3 conv tops.
- Reads a full KERNEL x KERNEL x CHANNEL_NUM_IN x CHANNEL_NUM_OUT weight set from a synchronous weight memory after a start pulse.
- Emits the weights as a serial valid/data stream in consumer order, with ready backpressure.
- Sits between the weight BRAM/DDR staging buffer and the conv top's weight port.

Parameters:
- DATA_WIDTH, 32, weight word width.
- CHANNEL_NUM_IN, 512, input channels per output channel.
- CHANNEL_NUM_OUT, 512, output channels.
- KERNEL, 3, kernel width = height.
- ADDR_WIDTH, 22, memory address width; must satisfy 2^ADDR_WIDTH >= TOTAL_WORDS.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a stream when idle.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the last word is accepted.
- mem_rd_en  output  1  memory read strobe.
- mem_addr  output  ADDR_WIDTH  memory word address.
- mem_rd_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- weight_ready  input  1  consumer can accept a word.
- valid_weight_out  output  1  weight_out holds a valid word.
- weight_out  output  DATA_WIDTH  weight word.

Behaviour:
- TOTAL_WORDS = CHANNEL_NUM_OUT*CHANNEL_NUM_IN*KERNEL*KERNEL.
- Stream order: oc outer, ic middle, tap inner (row-major ky,kx). mem_addr = oc*CHANNEL_NUM_IN*K*K + ic*K*K + ky*K + kx, i.e. a linear counter 0..TOTAL_WORDS-1.
- Reset (reset=0): state IDLE; all outputs 0; address counter, in-flight flag, buffer and accepted counter cleared. Reset mid-stream aborts silently with no done pulse.
- FSM states:
  - IDLE: start=1 -> STREAM; busy=1 from the next cycle.
  - STREAM: issues reads; after the read at TOTAL_WORDS-1 is issued -> DRAIN.
  - DRAIN: no reads; when the last word transfers (valid & ready) -> DONE.
  - DONE: done=1, busy=0 for one cycle -> IDLE.
- start is ignored when not IDLE. start in the DONE cycle is ignored.
- Output buffer: 2-entry FIFO with registered head. valid_weight_out = FIFO not empty; weight_out = head.
- Transfer occurs when valid_weight_out & weight_ready. valid_weight_out and weight_out stay stable while ready=0.
- Read issue rule: mem_rd_en=1 in STREAM iff (fifo_count + inflight - pop_this_cycle) < 2. This guarantees no overflow and no data loss.
- Returning data is pushed on the cycle it is valid. Simultaneous push and pop keeps the count.
- Latency: start sampled at edge E0 -> mem_rd_en addr 0 in cycle after E0 -> valid_weight_out high after E2.
- Throughput: 1 word/cycle sustained with weight_ready held high.
- done rises the cycle after the final transfer edge.
- Counters are wide enough for TOTAL_WORDS with no wrap. The address counter stops at TOTAL_WORDS-1; no read is issued beyond it.
- weight_ready toggled arbitrarily never duplicates, skips or reorders words.

Optional Feature:
- Macro WEIGHT_STREAM_CHECKSUM_EN.
- Defined: adds output checksum [DATA_WIDTH-1:0].
  - Cleared on accepted start.
  - XOR-accumulates every transferred word.
  - Holds its final value from the done pulse until the next accepted start.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package/include (alongside the conv param defs): TOTAL_WORDS and the FSM state encodings (IDLE=0, STREAM=1, DRAIN=2, DONE=3).
- ADDR_WIDTH is derived there via clog2(TOTAL_WORDS).
- One natural sub-module: weight_stream_fifo2 (2-deep FWFT FIFO with count output).

Test Plan (CHANNEL_NUM_IN=2, CHANNEL_NUM_OUT=2, KERNEL=3, TOTAL_WORDS=36, memory returns addr+100):
- Free-run: start, weight_ready=1 -> 36 consecutive words 100..135, first valid after E2, done 1 cycle after word 135, busy low after.
- Backpressure: weight_ready random 50% -> same 36-word sequence, no gaps in values, outputs stable while ready=0, mem_rd_en never makes fifo_count+inflight exceed 2.
- Ready held low 20 cycles after start -> exactly 2 reads issued (addr 0,1), then stall. Release -> stream resumes at 100,101,102...
- start pulsed again at word 10 and during DONE -> ignored; single 36-word stream, single done.
- reset asserted at word 20 -> all outputs 0 immediately, no done. New start -> stream restarts at 100.
- WEIGHT_STREAM_CHECKSUM_EN defined, free-run -> checksum = XOR of 100..135 at done, held until next start.
